slt_bist_seq: RTL and testbench

- Hardware self-test sequencer for the parameterised set-less-than unit `slt_mod`; it is the initiator side of that unit's operand/result interface.
- Drives every R2/R3 operand pair into a `slt_mod` instance and samples the R1 result after a fixed settle time.
- Compares R1 against an internal golden signed compare and reports the error count, the first failing vector, and pass/fail.
- Sits beside the ALU as an on-chip BIST replacing the free-running simulation stimulus.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/slt_bist_ctr.sv | 46 ++++
 rtl/slt_bist_seq.sv | 139 +++++++++++++
 tb/tb_slt_bist_seq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the set-less-than BIST: sequencer states,
// the golden signed compare and per-width extreme-value helpers.
`default_nettype none

package alu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        CHECK = 3'd2,
        ADV   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Most negative sz-bit two's-complement value, zero-extended to 32 bits.
    function automatic logic [31:0] most_neg(input int sz);
        return 32'd1 << (sz - 1);
    endfunction

    function automatic logic [31:0] most_pos(input int sz);
        return most_neg(sz) - 32'd1;
    endfunction

    // Golden result for sz-bit operands held in the low bits of a and b.
    // Flipping the sign bit turns a signed compare into an unsigned one.
    function automatic logic [31:0] slt_expect(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input int          sz);
        logic [31:0] mask;
        logic [31:0] am;
        logic [31:0] bm;
        mask = (sz >= 32) ? 32'hFFFF_FFFF : ((32'd1 << sz) - 32'd1);
        am   = (a & mask) ^ most_neg(sz);
        bm   = (b & mask) ^ most_neg(sz);
        return {31'd0, (am < bm)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/slt_bist_ctr.sv
// Operand pair counter for the BIST sweep: R2 outer loop, R3 inner loop,
// both starting at the most negative value and wrapping through positive.
`default_nettype none

module slt_bist_ctr
    import alu_pkg::*;
#(
    parameter int size = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_adv,
    output logic [size-1:0] o_r2,
    output logic [size-1:0] o_r3,
    output logic            o_last
);

    localparam logic [size-1:0] C_NEG = size'(most_neg(size));
    localparam logic [size-1:0] C_POS = size'(most_pos(size));

    logic [size-1:0] r_r2;
    logic [size-1:0] r_r3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r2 <= C_NEG;
            r_r3 <= C_NEG;
        end else if (i_load) begin
            r_r2 <= C_NEG;
            r_r3 <= C_NEG;
        end else if (i_adv) begin
            r_r3 <= r_r3 + size'(1);
            if (r_r3 == C_POS) begin
                r_r2 <= r_r2 + size'(1);
            end
        end
    end

    assign o_r2   = r_r2;
    assign o_r3   = r_r3;
    assign o_last = (r_r2 == C_POS) && (r_r3 == C_POS);

endmodule

`default_nettype wire

// File: rtl/slt_bist_seq.sv
// BIST sequencer for slt_mod: sweeps every operand pair, checks R1 against
// a golden signed compare, and logs error count and first failing vector.
`default_nettype none

module slt_bist_seq
    import alu_pkg::*;
#(
    parameter int size   = 4,
    parameter int SETTLE = 2,
    parameter int ERRW   = 2 * size + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [size-1:0] R2,
    output logic [size-1:0] R3,
    input  logic [size-1:0] R1,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_count,
    output logic [size-1:0] fail_R2,
    output logic [size-1:0] fail_R3
);

    localparam int            CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_settle;
    logic            w_load;
    logic            w_adv;
    logic            w_last;
    logic            w_mismatch;
    logic [ERRW-1:0] r_err;
    logic [size-1:0] r_fail_r2;
    logic [size-1:0] r_fail_r3;
    logic            r_found;

    slt_bist_ctr #(
        .size(size)
    ) u_ctr (
        .clk   (clk),
        .rst   (rst),
        .i_load(w_load),
        .i_adv (w_adv),
        .o_r2  (R2),
        .o_r3  (R3),
        .o_last(w_last)
    );

    // Full-width compare so any nonzero upper bit of R1 counts as a mismatch.
    assign w_mismatch = (32'(R1) != slt_expect(32'(R2), 32'(R3), size));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_adv  = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (r_settle == SETTLE_LAST) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                w_next = ADV;
            end
            ADV: begin
                if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_adv  = 1'b1;
                    w_next = WAIT;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle <= '0;
        end else if ((r_state == WAIT) && (w_next == WAIT)) begin
            r_settle <= r_settle + CW'(1);
        end else begin
            r_settle <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err     <= '0;
            r_fail_r2 <= '0;
            r_fail_r3 <= '0;
            r_found   <= 1'b0;
        end else if (w_load) begin
            r_err     <= '0;
            r_fail_r2 <= '0;
            r_fail_r3 <= '0;
            r_found   <= 1'b0;
        end else if ((r_state == CHECK) && w_mismatch) begin
            if (r_err != {ERRW{1'b1}}) begin
                r_err <= r_err + ERRW'(1);
            end
            if (!r_found) begin
                r_fail_r2 <= R2;
                r_fail_r3 <= R3;
                r_found   <= 1'b1;
            end
        end
    end

    assign busy      = (r_state == WAIT) || (r_state == CHECK) || (r_state == ADV);
    assign done      = (r_state == DONE);
    assign pass      = done && (r_err == '0);
    assign err_count = r_err;
    assign fail_R2   = r_fail_r2;
    assign fail_R3   = r_fail_r3;

endmodule

`default_nettype wire

// File: tb/tb_slt_bist_seq.sv
// Directed bench for slt_bist_seq: swept against golden and faulty slt_mod models.
`default_nettype none

module tb_slt_bist_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // size=4, SETTLE=2 instance
    logic       start_a;
    logic [3:0] r2_a, r3_a, r1_a;
    logic       busy_a, done_a, pass_a;
    logic [8:0] err_a;
    logic [3:0] f2_a, f3_a;
    int         mode;

    // size=2, SETTLE=1, ERRW=3 instance with R1 stuck at 2'b11
    logic       start_b;
    logic [1:0] r2_b, r3_b;
    logic [1:0] r1_b;
    logic       busy_b, done_b, pass_b;
    logic [2:0] err_b;
    logic [1:0] f2_b, f3_b;

    assign r1_b = 2'b11;

    always_comb begin
        case (mode)
            0:       r1_a = {3'b000, ($signed(r2_a) < $signed(r3_a))};
            1:       r1_a = 4'b0001;
            2:       r1_a = {3'b000, ($signed(r2_a) < $signed(r3_a))} | 4'b0100;
            default: r1_a = {3'b000, (r2_a < r3_a)};
        endcase
    end

    slt_bist_seq #(.size(4), .SETTLE(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .R2(r2_a), .R3(r3_a), .R1(r1_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_R2(f2_a), .fail_R3(f3_a)
    );

    slt_bist_seq #(.size(2), .SETTLE(1), .ERRW(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .R2(r2_b), .R3(r3_b), .R1(r1_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_R2(f2_b), .fail_R3(f3_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse start on instance A and count cycles (start cycle included) until done.
    task automatic run_sweep(input int glitch_at, output int cycles);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        cycles = 1;
        chk("busy_after_start", {31'd0, busy_a}, 32'd1);
        chk("done_after_start", {31'd0, done_a}, 32'd0);
        while (!done_a && cycles < 3000) begin
            if (cycles == glitch_at) start_a = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0;
            cycles++;
        end
    endtask

    typedef struct {
        int         mode;
        int         exp_err;
        logic       exp_pass;
        logic [3:0] exp_f2;
        logic [3:0] exp_f3;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int cyc;
        vecs[0] = '{0,   0, 1'b1, 4'b0000, 4'b0000};
        vecs[1] = '{1, 136, 1'b0, 4'b1000, 4'b1000};
        vecs[2] = '{2, 256, 1'b0, 4'b1000, 4'b1000};
        vecs[3] = '{3, 128, 1'b0, 4'b1000, 4'b0000};

        mode    = 0;
        start_a = 1'b0;
        start_b = 1'b0;
        rst     = 1'b1;
        #12;
        chk("rst_busy",  {31'd0, busy_a}, 32'd0);
        chk("rst_done",  {31'd0, done_a}, 32'd0);
        chk("rst_pass",  {31'd0, pass_a}, 32'd0);
        chk("rst_err",   {23'd0, err_a},  32'd0);
        chk("rst_R2",    {28'd0, r2_a},   32'd8);
        chk("rst_R3",    {28'd0, r3_a},   32'd8);
        chk("rst_fail",  {24'd0, f2_a, f3_a}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            mode = vecs[i].mode;
            run_sweep(-1, cyc);
            chk($sformatf("v%0d_cycles", i), cyc, 32'd1025);
            chk($sformatf("v%0d_done", i), {31'd0, done_a}, 32'd1);
            chk($sformatf("v%0d_busy", i), {31'd0, busy_a}, 32'd0);
            chk($sformatf("v%0d_err", i), {23'd0, err_a}, vecs[i].exp_err);
            chk($sformatf("v%0d_pass", i), {31'd0, pass_a}, {31'd0, vecs[i].exp_pass});
            chk($sformatf("v%0d_fail_R2", i), {28'd0, f2_a}, {28'd0, vecs[i].exp_f2});
            chk($sformatf("v%0d_fail_R3", i), {28'd0, f3_a}, {28'd0, vecs[i].exp_f3});
            repeat (3) @(posedge clk);
            #1 chk($sformatf("v%0d_done_hold", i), {31'd0, done_a}, 32'd1);
        end

        // Start pulsed mid-sweep must not disturb the sweep.
        mode = 0;
        run_sweep(200, cyc);
        chk("glitch_cycles", cyc, 32'd1025);
        chk("glitch_pass", {31'd0, pass_a}, 32'd1);

        // Asynchronous reset at cycle 300 of a faulty sweep.
        mode = 1;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (299) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        chk("mid_rst_done", {31'd0, done_a}, 32'd0);
        chk("mid_rst_err",  {23'd0, err_a},  32'd0);
        chk("mid_rst_fail", {24'd0, f2_a, f3_a}, 32'd0);
        chk("mid_rst_R2R3", {24'd0, r2_a, r3_a}, 32'h88);
        @(posedge clk); #1 rst = 1'b0;
        mode = 0;
        run_sweep(-1, cyc);
        chk("restart_cycles", cyc, 32'd1025);
        chk("restart_pass", {31'd0, pass_a}, 32'd1);

        // Saturating error counter on the 2-bit instance: 1 + 16*3 = 49 cycles.
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        cyc = 1;
        while (!done_b && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("sat_cycles", cyc, 32'd49);
        chk("sat_err",    {29'd0, err_b}, 32'd7);
        chk("sat_pass",   {31'd0, pass_b}, 32'd0);
        chk("sat_fail",   {28'd0, f2_b, f3_b}, 32'b1010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
